// File: rtl/aes_ctr_xor.sv
// AES-CTR keystream XOR stage: launches AES on the stored counter block, latches the
// keystream and XORs a little-endian word stream with it. Optional macro: CTR_BLOCK_COUNT_EN.
module aes_ctr_xor #(
  parameter int unsigned WORDS     = 4,
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [WORDS*WORD_SIZE-1:0]   ctr_block,
  output logic                         ctr_inc,
  output logic                         aes_start,
  output logic [WORDS*WORD_SIZE-1:0]   aes_in,
  input  logic                         aes_done,
  input  logic [WORDS*WORD_SIZE-1:0]   aes_out,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_SIZE-1:0]         in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_SIZE-1:0]         out_data,
  output logic                         out_last,
  output logic                         busy
`ifdef CTR_BLOCK_COUNT_EN
  ,
  output logic [31:0]                  block_count
`endif
);

  localparam int unsigned IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned BYTES = WORD_SIZE / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, STREAM} state_e;

  state_e                       state_q, state_d;
  logic [WORDS*WORD_SIZE-1:0]   aes_in_q;
  logic [WORDS*WORD_SIZE-1:0]   ks_q;
  logic [IDXW-1:0]              idx_q;
  logic                         out_valid_q;
  logic [WORD_SIZE-1:0]         out_data_q;
  logic                         out_last_q;

  logic                         in_hs;
  logic                         out_hs;
  logic                         last_word;
  logic [WORD_SIZE-1:0]         ks_slice;
  logic [WORD_SIZE-1:0]         ks_word;

  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid_q & out_ready;
  assign last_word = (idx_q == IDXW'(WORDS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    if (aes_done) state_d = STREAM;
      STREAM:  if (in_hs && (last_word || in_last)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    aes_start = (state_q == REQ);
    ctr_inc   = (state_q == WAIT) && aes_done;
    busy      = (state_q != IDLE);
    in_ready  = (state_q == STREAM) && (!out_valid_q || out_ready);
  end

  // Word 0 is the most significant AES slice; bytes are reversed to little-endian order.
  always_comb begin
    ks_slice = '0;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (idx_q == IDXW'(k)) ks_slice = ks_q[(WORDS-1-k)*WORD_SIZE +: WORD_SIZE];
    end
    ks_word = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      ks_word[b*8 +: 8] = ks_slice[(BYTES-1-b)*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aes_in_q    <= '0;
      ks_q        <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      // Loaded on entry to REQ so aes_in is already valid during the start pulse.
      if (state_q == IDLE && enable) aes_in_q <= ctr_block;
      if (ctr_inc) begin
        ks_q  <= aes_out;
        idx_q <= '0;
      end
      if (in_hs) begin
        out_data_q  <= in_data ^ ks_word;
        out_last_q  <= in_last;
        out_valid_q <= 1'b1;
        idx_q       <= idx_q + 1'b1;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign aes_in    = aes_in_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

`ifdef CTR_BLOCK_COUNT_EN
  logic [31:0] block_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              block_count_q <= '0;
    else if (state_q == IDLE && !enable)  block_count_q <= '0;
    else if (ctr_inc)                     block_count_q <= block_count_q + 32'd1;
  end

  assign block_count = block_count_q;
`endif

endmodule

// File: doc/aes_ctr_xor.md
Name: aes_ctr_xor

Overview:
Downstream consumer of the counter/key RAM's stored counter block in the AES-CTR datapath. Per block, it launches the AES core on the current counter and latches the keystream. It pulses the counter RAM's increment once per block, then XORs a stream of little-endian input words with the keystream. Results go out on a valid/ready stream, converting the big-endian AES block back to little-endian word order.

Parameters:
WORDS, 4, words per AES block
WORD_SIZE, 32, bits per stream word; must be a multiple of 8

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
enable  in  1  level; allows a new block to start from IDLE
ctr_block  in  WORDS*WORD_SIZE  counter block from the counter RAM (big-endian)
ctr_inc  out  1  one-cycle increment pulse to the counter RAM
aes_start  out  1  one-cycle start pulse to the AES core
aes_in  out  WORDS*WORD_SIZE  block presented to the AES core
aes_done  in  1  one-cycle AES completion strobe
aes_out  in  WORDS*WORD_SIZE  AES result, valid when aes_done=1
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid&in_ready
in_data  in  WORD_SIZE  plaintext/ciphertext word (little-endian bytes)
in_last  in  1  marks the final word of the message
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts when out_valid&out_ready
out_data  out  WORD_SIZE  XOR result
out_last  out  1  copy of in_last for this word
busy  out  1  high when state != IDLE; software must not write the counter RAM while busy

Behaviour:
- Reset is asynchronous, active-high. All outputs go to 0: ctr_inc, aes_start, aes_in, in_ready, out_valid, out_data, out_last, busy. State goes to IDLE, the keystream register and word index clear to 0. Reset mid-block abandons the block with no further pulses.
- States:
  - IDLE: if enable, go to REQ.
  - REQ: for one cycle, aes_start=1 and aes_in=ctr_block. aes_in is registered and held until the next REQ. Go to WAIT.
  - WAIT: on aes_done, latch aes_out into ks, pulse ctr_inc=1 for exactly one cycle, clear idx, go to STREAM.
  - STREAM: consume words; on the final handshake go to IDLE.
- aes_done outside WAIT is ignored.
- Keystream word mapping: word idx k pairs with ks[(WORDS-k)*WORD_SIZE-1 : (WORDS-1-k)*WORD_SIZE], byte-reversed within the word. Word 0 is the most significant AES slice.
- in_ready = (state==STREAM) & (!out_valid | out_ready).
- On an input handshake: out_data <= in_data ^ ks_word(idx), out_last <= in_last, out_valid <= 1, idx <= idx+1. Latency is 1 cycle, with full throughput when out_ready stays high.
- out_valid clears on an output handshake with no simultaneous input handshake. Output is held stable while out_valid & !out_ready.
- Block end: a handshake with idx==WORDS-1, or with in_last=1 (partial block), returns to IDLE.
  - Remaining keystream is discarded; the counter has already been incremented.
  - The next block restarts at REQ only while enable=1.
- Leaving STREAM does not drop a pending out_valid; it drains normally.
- idx is $clog2(WORDS) bits wide. It never wraps inside a block and resets to 0 on each WAIT→STREAM transition.
- enable falling during REQ/WAIT/STREAM does not abort the current block.

Optional Feature:
CTR_BLOCK_COUNT_EN.
- Defined: adds output block_count [31:0], reset 0. It increments by 1 on each ctr_inc pulse, wraps 0xFFFFFFFF→0, and is cleared when enable=0 in IDLE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Full block. Setup: WORDS=4, WORD_SIZE=32, enable=1, aes_done 3 cycles after aes_start with aes_out=128'h00112233_44556677_8899aabb_ccddeeff. Stimulus: in_data=FFFFFFFF,0,0,00000000 with out_ready=1. Response: out_data CCDDEEFF, 77665544, BBAA9988, FFEEDDCC; exactly one ctr_inc pulse and one aes_start pulse; aes_in equals ctr_block at REQ.
- Back-pressure. Stimulus: hold out_ready=0 after the first word. Response: in_ready=0; out_data stays CCDDEEFF until out_ready=1; no word is lost or duplicated.
- Partial block. Stimulus: in_last=1 on word 1. Response: out_last=1 on the second output; FSM returns to IDLE; the next block issues a new aes_start and a second ctr_inc.
- Spurious aes_done. Stimulus: aes_done pulsed in IDLE and in STREAM. Response: no state change, ks unchanged, no ctr_inc.
- Reset mid-WAIT. Stimulus: rst asserted one cycle after aes_start. Response: all outputs 0 immediately, busy=0, no ctr_inc.
- With CTR_BLOCK_COUNT_EN. Stimulus: 3 full blocks. Response: block_count=3; it clears to 0 after enable drops in IDLE.
